// File: rtl/jtvigil_rom_arb_pkg.sv
// Shared definitions for the jtvigil ROM slot arbiter.
// Holds the FSM state encoding, the client index constants and the
// round-robin pick helper used by the arbiter top level.
package jtvigil_rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  localparam logic CLIENT0 = 1'b0;  // object line drawer
  localparam logic CLIENT1 = 1'b1;  // scroll/tile fetcher

  // Round-robin choice: a lone pending client wins outright; on a tie the
  // client that was not served last wins.
  function automatic logic pick_client(input logic pend0, input logic pend1,
                                       input logic last_gnt);
    logic sel;
    if (pend0 && pend1) begin
      sel = ~last_gnt;
    end else if (pend0) begin
      sel = CLIENT0;
    end else begin
      sel = CLIENT1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/jtvigil_rom_arb_cache.sv
// One-entry hit cache for a single ROM fetch client.
// Keeps the last address served to the client, its data and a valid flag.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cs_i, addr_i  client request and address
//   load_i        capture load_addr_i/load_data_i and mark the entry valid
//   data_o        latched data returned to the client
//   hit_o         entry valid and address matches (ignores cs_i)
//   ok_o          client is requesting and hits the entry
module jtvigil_rom_arb_cache #(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [DW-1:0] load_data_i,
  output logic [DW-1:0] data_o,
  output logic          hit_o,
  output logic          ok_o
);

  logic [AW-1:0] la_q, la_d;
  logic [DW-1:0] data_q, data_d;
  logic          v_q, v_d;

  always_comb begin
    la_d   = la_q;
    data_d = data_q;
    v_d    = v_q;
    if (load_i) begin
      la_d   = load_addr_i;
      data_d = load_data_i;
      v_d    = 1'b1;
    end
  end

  // The entry only ever invalidates on reset; a new address forces a refetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      la_q   <= '0;
      data_q <= '0;
      v_q    <= 1'b0;
    end else begin
      la_q   <= la_d;
      data_q <= data_d;
      v_q    <= v_d;
    end
  end

  assign hit_o  = v_q && (addr_i == la_q);
  assign ok_o   = cs_i && hit_o;
  assign data_o = data_q;

endmodule

// File: rtl/jtvigil_rom_arb.sv
// Two-client arbiter for a single SDRAM ROM slot.
// Client 0 (object line drawer) and client 1 (scroll/tile fetcher) each get
// a private cs/addr/data/ok port backed by a one-entry hit cache. Misses are
// sequenced onto the SDRAM slot round-robin; sd_ok is masked for OKDLY
// cycles after issue so a stale ok from the previous access is never taken.
// Ports:
//   rst, clk                 asynchronous active-high reset, clock
//   c0_cs/c0_addr/c0_data/c0_ok   client 0 port
//   c1_cs/c1_addr/c1_data/c1_ok   client 1 port
//   sd_cs/sd_addr/sd_data/sd_ok   SDRAM slot port
//   busy                     a transaction is in flight (state != IDLE)
module jtvigil_rom_arb
  import jtvigil_rom_arb_pkg::*;
#(
  parameter int AW    = 18,
  parameter int DW    = 32,
  parameter int OKDLY = 2
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          c0_cs,
  input  logic [AW-1:0] c0_addr,
  output logic [DW-1:0] c0_data,
  output logic          c0_ok,
  input  logic          c1_cs,
  input  logic [AW-1:0] c1_addr,
  output logic [DW-1:0] c1_data,
  output logic          c1_ok,
  output logic          sd_cs,
  output logic [AW-1:0] sd_addr,
  input  logic [DW-1:0] sd_data,
  input  logic          sd_ok,
  output logic          busy
);

  localparam int AGEW = (OKDLY < 1) ? 1 : $clog2(OKDLY + 1);
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(OKDLY);

  arb_state_t    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic [AGEW-1:0] age_q, age_d;
  logic          sd_cs_q, sd_cs_d;
  logic [AW-1:0] sd_addr_q, sd_addr_d;

  logic          hit0, hit1;
  logic          pend0, pend1;
  logic          load0, load1;
  logic          g_cs;
  logic [AW-1:0] g_addr;
  logic          g_match;
  logic          qual_ok;
  logic          pick;

  jtvigil_rom_arb_cache #(.AW(AW), .DW(DW)) u_cache0 (
    .clk        (clk),
    .rst        (rst),
    .cs_i       (c0_cs),
    .addr_i     (c0_addr),
    .load_i     (load0),
    .load_addr_i(sd_addr_q),
    .load_data_i(sd_data),
    .data_o     (c0_data),
    .hit_o      (hit0),
    .ok_o       (c0_ok)
  );

  jtvigil_rom_arb_cache #(.AW(AW), .DW(DW)) u_cache1 (
    .clk        (clk),
    .rst        (rst),
    .cs_i       (c1_cs),
    .addr_i     (c1_addr),
    .load_i     (load1),
    .load_addr_i(sd_addr_q),
    .load_data_i(sd_data),
    .data_o     (c1_data),
    .hit_o      (hit1),
    .ok_o       (c1_ok)
  );

  assign pend0 = c0_cs && !hit0;
  assign pend1 = c1_cs && !hit1;
  assign pick  = pick_client(pend0, pend1, last_gnt_q);

  // The granted client must still want exactly the address on the slot,
  // otherwise the returning data belongs to nobody.
  assign g_cs    = (gnt_q == CLIENT1) ? c1_cs   : c0_cs;
  assign g_addr  = (gnt_q == CLIENT1) ? c1_addr : c0_addr;
  assign g_match = g_cs && (g_addr == sd_addr_q);
  assign qual_ok = sd_ok && (age_q == AGE_MAX);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    age_d      = age_q;
    sd_cs_d    = sd_cs_q;
    sd_addr_d  = sd_addr_q;
    load0      = 1'b0;
    load1      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          gnt_d     = pick;
          sd_addr_d = (pick == CLIENT1) ? c1_addr : c0_addr;
          sd_cs_d   = 1'b1;
          age_d     = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (age_q != AGE_MAX) age_d = age_q + AGEW'(1);
        if (!g_match) begin
          // The SDRAM request cannot be withdrawn; if its ok is already
          // qualified this cycle, discard it right away.
          if (qual_ok) begin
            sd_cs_d    = 1'b0;
            last_gnt_d = gnt_q;
            state_d    = ST_GAP;
          end else begin
            state_d = ST_DROP;
          end
        end else if (qual_ok) begin
          load0      = (gnt_q == CLIENT0);
          load1      = (gnt_q == CLIENT1);
          sd_cs_d    = 1'b0;
          last_gnt_d = gnt_q;
          state_d    = ST_GAP;
        end
      end
      ST_DROP: begin
        if (age_q != AGE_MAX) age_d = age_q + AGEW'(1);
        if (qual_ok) begin
          sd_cs_d    = 1'b0;
          last_gnt_d = gnt_q;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        // One low cycle on sd_cs so the controller sees a fresh edge.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= CLIENT0;
      last_gnt_q <= CLIENT1;  // client 0 wins the first tie
      age_q      <= '0;
      sd_cs_q    <= 1'b0;
      sd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      age_q      <= age_d;
      sd_cs_q    <= sd_cs_d;
      sd_addr_q  <= sd_addr_d;
    end
  end

  assign sd_cs   = sd_cs_q;
  assign sd_addr = sd_addr_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jtvigil_rom_arb.sv
// Self-checking bench for jtvigil_rom_arb: scripted sequences for the
// multi-cycle cases, a per-client scoreboard of expected fetch data, and a
// table of combinational hit vectors.
module tb_jtvigil_rom_arb;

  localparam int AW    = 18;
  localparam int DW    = 32;
  localparam int OKDLY = 2;

  logic          rst, clk;
  logic          c0_cs, c1_cs;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_data, c1_data;
  logic          c0_ok, c1_ok;
  logic          sd_cs;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_data;
  logic          sd_ok;
  logic          busy;

  logic          ovr_en;
  logic [DW-1:0] ovr_val;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            glog[$];

  typedef struct {
    logic          cs0;
    logic [AW-1:0] a0;
    logic          cs1;
    logic [AW-1:0] a1;
    logic          ok0;
    logic          ok1;
  } vec_t;
  vec_t tbl[6];

  logic [AW-1:0] a0_list[4];
  logic [AW-1:0] a1_list[4];

  jtvigil_rom_arb #(.AW(AW), .DW(DW), .OKDLY(OKDLY)) dut (
    .rst    (rst),
    .clk    (clk),
    .c0_cs  (c0_cs),
    .c0_addr(c0_addr),
    .c0_data(c0_data),
    .c0_ok  (c0_ok),
    .c1_cs  (c1_cs),
    .c1_addr(c1_addr),
    .c1_data(c1_data),
    .c1_ok  (c1_ok),
    .sd_cs  (sd_cs),
    .sd_addr(sd_addr),
    .sd_data(sd_data),
    .sd_ok  (sd_ok),
    .busy   (busy)
  );

  // SDRAM content model: data is a fixed scramble of the address.
  function automatic logic [DW-1:0] sdmodel(input logic [AW-1:0] a);
    return {a[13:0], a} ^ 32'h9E37_0000;
  endfunction

  assign sd_data = ovr_en ? ovr_val : sdmodel(sd_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic wait_cs(input string nm);
    int n;
    n = 0;
    while (!sd_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sd_cs) begin
      checks++;
      failures++;
      $display("FAIL %s timeout sd_cs=%0b required=1", nm, sd_cs);
    end
  endtask

  task automatic wait_ok0(input string nm);
    int n;
    n = 0;
    while (!c0_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!c0_ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout c0_ok=%0b required=1", nm, c0_ok);
    end
  endtask

  initial begin
    int i0, i1, lowrun;
    logic prev_cs;
    logic [DW-1:0] e;

    tbl[0] = '{1'b1, 18'h00204, 1'b1, 18'h2A000, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 18'h00204, 1'b1, 18'h2A000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 18'h00204, 1'b0, 18'h2A000, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 18'h00205, 1'b1, 18'h2A000, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 18'h00204, 1'b1, 18'h0A000, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 18'h20204, 1'b1, 18'h2A000, 1'b0, 1'b1};
    a0_list = '{18'h01000, 18'h01004, 18'h01008, 18'h0100C};
    a1_list = '{18'h2A00C, 18'h2A008, 18'h2A004, 18'h2A000};

    rst = 1'b1; c0_cs = 1'b0; c1_cs = 1'b0; c0_addr = '0; c1_addr = '0;
    sd_ok = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_sd_cs", {31'd0, sd_cs}, 32'd0);
    chk("rst_sd_addr", {14'd0, sd_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_c0_data", c0_data, 32'd0);
    chk("rst_c1_data", c1_data, 32'd0);
    rst = 1'b0;

    // Single client, sd_ok tied high: ok on the (OKDLY+3)th cycle counting
    // the address presentation cycle as the first.
    @(negedge clk);
    c0_cs = 1'b1; c0_addr = 18'h00100; sd_ok = 1'b1;
    #1 chk("single_c0_ok_miss", {31'd0, c0_ok}, 32'd0);
    @(negedge clk);
    chk("single_sd_cs", {31'd0, sd_cs}, 32'd1);
    chk("single_sd_addr", {14'd0, sd_addr}, 32'h00100);
    chk("single_busy", {31'd0, busy}, 32'd1);
    repeat (OKDLY) @(negedge clk);
    chk("single_ok_early", {31'd0, c0_ok}, 32'd0);
    @(negedge clk);
    chk("single_c0_ok", {31'd0, c0_ok}, 32'd1);
    chk("single_c0_data", c0_data, sdmodel(18'h00100));
    chk("single_c1_ok", {31'd0, c1_ok}, 32'd0);
    chk("single_gap_sd_cs", {31'd0, sd_cs}, 32'd0);
    repeat (2) @(negedge clk);
    chk("single_idle_busy", {31'd0, busy}, 32'd0);

    // Stale ok: an ok on the issue cycle must be ignored.
    sd_ok = 1'b0; c0_addr = 18'h00300;
    @(negedge clk);
    wait_cs("stale_issue");
    sd_ok = 1'b1;
    @(negedge clk);
    sd_ok = 1'b0;
    chk("stale_early_ok_m2", {31'd0, c0_ok}, 32'd0);
    repeat (4) @(negedge clk);
    chk("stale_early_ok_m6", {31'd0, c0_ok}, 32'd0);
    sd_ok = 1'b1; ovr_en = 1'b1; ovr_val = 32'hCAFEF00D;
    @(negedge clk);
    chk("stale_late_ok", {31'd0, c0_ok}, 32'd1);
    chk("stale_late_data", c0_data, 32'hCAFEF00D);
    sd_ok = 1'b0; ovr_en = 1'b0;

    // Contention: both clients stream four new addresses each.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sd_ok = 1'b1;
    i0 = 0; i1 = 0; lowrun = 0; prev_cs = 1'b0;
    c0_cs = 1'b1; c0_addr = a0_list[0]; exp_q0.push_back(sdmodel(a0_list[0]));
    c1_cs = 1'b1; c1_addr = a1_list[0]; exp_q1.push_back(sdmodel(a1_list[0]));
    for (int cyc = 0; cyc < 200 && (i0 < 4 || i1 < 4); cyc++) begin
      @(negedge clk);
      if (sd_cs && !prev_cs) begin
        glog.push_back((sd_addr == c0_addr) ? 0 : ((sd_addr == c1_addr) ? 1 : 2));
        if (glog.size() > 1) chk("cont_gap_low", {31'd0, lowrun >= 1}, 32'd1);
      end
      lowrun  = sd_cs ? 0 : lowrun + 1;
      prev_cs = sd_cs;
      if (c0_ok && i0 < 4) begin
        e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hDEAD_BEEF;
        chk("cont_c0_data", c0_data, e);
        i0++;
        if (i0 < 4) begin
          c0_addr = a0_list[i0];
          exp_q0.push_back(sdmodel(a0_list[i0]));
        end
      end
      if (c1_ok && i1 < 4) begin
        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hDEAD_BEEF;
        chk("cont_c1_data", c1_data, e);
        i1++;
        if (i1 < 4) begin
          c1_addr = a1_list[i1];
          exp_q1.push_back(sdmodel(a1_list[i1]));
        end
      end
    end
    chk("cont_c0_done", i0, 4);
    chk("cont_c1_done", i1, 4);
    chk("cont_grants", glog.size(), 8);
    for (int k = 0; k < glog.size(); k++) chk("cont_order", glog[k], k % 2);

    // Hit: c1 sits at 0x2A000, toggling cs costs no slot cycles.
    @(negedge clk);
    c1_cs = 1'b0;
    #1 chk("hit_c1_ok_low", {31'd0, c1_ok}, 32'd0);
    @(negedge clk);
    c1_cs = 1'b1;
    #1 chk("hit_c1_ok", {31'd0, c1_ok}, 32'd1);
    chk("hit_c1_data", c1_data, sdmodel(18'h2A000));
    chk("hit_sd_cs", {31'd0, sd_cs}, 32'd0);
    @(negedge clk);
    chk("hit_sd_cs_next", {31'd0, sd_cs}, 32'd0);
    chk("hit_busy", {31'd0, busy}, 32'd0);

    // Abort: c0 moves its address while the slot request is outstanding.
    sd_ok = 1'b0; c0_addr = 18'h00200;
    @(negedge clk);
    wait_cs("abort_issue");
    chk("abort_sd_addr", {14'd0, sd_addr}, 32'h00200);
    c0_addr = 18'h00204;
    repeat (2) @(negedge clk);
    chk("abort_hold_sd_cs", {31'd0, sd_cs}, 32'd1);
    sd_ok = 1'b1;
    @(negedge clk);
    chk("abort_drop_sd_cs", {31'd0, sd_cs}, 32'd0);
    chk("abort_c0_ok", {31'd0, c0_ok}, 32'd0);
    chk("abort_c0_data_kept", c0_data, sdmodel(18'h0100C));
    exp_q0.push_back(sdmodel(18'h00204));
    wait_cs("abort_reissue");
    chk("abort_reissue_addr", {14'd0, sd_addr}, 32'h00204);
    wait_ok0("abort_refetch");
    e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hDEAD_BEEF;
    chk("abort_refetch_data", c0_data, e);

    // Table of combinational hit vectors against the loaded caches.
    sd_ok = 1'b0;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      c0_cs = tbl[r].cs0; c0_addr = tbl[r].a0;
      c1_cs = tbl[r].cs1; c1_addr = tbl[r].a1;
      #1;
      chk($sformatf("tbl%0d_ok0", r), {31'd0, c0_ok}, {31'd0, tbl[r].ok0});
      chk($sformatf("tbl%0d_ok1", r), {31'd0, c1_ok}, {31'd0, tbl[r].ok1});
      if (tbl[r].ok0) chk($sformatf("tbl%0d_d0", r), c0_data, sdmodel(18'h00204));
      if (tbl[r].ok1) chk($sformatf("tbl%0d_d1", r), c1_data, sdmodel(18'h2A000));
    end

    // Let any dropped request drain, then reset in the middle of a request.
    @(negedge clk);
    c0_cs = 1'b1; c0_addr = 18'h00204; c1_cs = 1'b1; c1_addr = 18'h2A000;
    sd_ok = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain_busy", {31'd0, busy}, 32'd0);
    sd_ok = 1'b0; c0_addr = 18'h00400;
    @(negedge clk);
    wait_cs("rstmid_issue");
    @(negedge clk);
    chk("rstmid_pre_c1_ok", {31'd0, c1_ok}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_sd_cs", {31'd0, sd_cs}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_c0_ok", {31'd0, c0_ok}, 32'd0);
    chk("rstmid_c1_ok", {31'd0, c1_ok}, 32'd0);
    chk("rstmid_c1_data", c1_data, 32'd0);
    @(negedge clk);
    rst = 1'b0; c0_cs = 1'b0; c1_cs = 1'b0; sd_ok = 1'b1;
    repeat (3) @(negedge clk);
    sd_ok = 1'b0;
    chk("post_rst_c0_data", c0_data, 32'd0);
    chk("post_rst_c1_data", c1_data, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_sd_cs", {31'd0, sd_cs}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
